// File: rtl/spi_cmd_rx_if.sv
// SPI pin bundle plus decoded command fields and event pulses for spi_cmd_rx.
// The slave modport is the receiver's view; master is the controller/consumer view.
interface spi_cmd_rx_if #(
    parameter int STATUS_W = 16
);
    logic                spi_clk;
    logic                spi_cs;
    logic                spi_mosi;
    logic                spi_miso;
    logic [STATUS_W-1:0] status;
    logic                frame_valid;
    logic                frame_err;
    logic                overrun;
    logic                busy;
    logic [3:0]          cmd;
    logic [11:0]         aux;
    logic [24:0]         data;
    logic [3:0]          dev;
    logic                wr;
    logic [3:0]          tag;

    modport slave (
        input  spi_clk, spi_cs, spi_mosi, status,
        output spi_miso, frame_valid, frame_err, overrun, busy,
        output cmd, aux, data, dev, wr, tag
    );

    modport master (
        output spi_clk, spi_cs, spi_mosi, status,
        input  spi_miso, frame_valid, frame_err, overrun, busy,
        input  cmd, aux, data, dev, wr, tag
    );
endinterface

// File: rtl/spi_cmd_rx.sv
// Oversampled SPI slave decoding a 50-bit LSB-first command frame; status readback when SPI_CMD_RX_MISO_EN is defined.
// Fields/frame_valid appear SYNC_STAGES+2 clk after the 50th SPI rising edge; no backpressure, events are single-cycle pulses.
module spi_cmd_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int STATUS_W    = 16
) (
    input  logic         clk,
    input  logic         rst,
    spi_cmd_rx_if.slave  bus
);
    localparam int FRAME_W = 50;

    typedef enum logic [1:0] {IDLE, RX, DONE, DRAIN} state_t;

    // Synchronizers are deliberately not reset so the pin levels stay valid
    // through reset; the post-reset state depends on the real chip-select level.
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic sclk_q, sclk_p;
    logic cs_q, cs_p;
    logic mosi_q, mosi_p;
    logic sclk_rise, cs_rise, cs_fall;

    always_ff @(posedge clk) begin
        sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_clk};
        cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   bus.spi_cs};
        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
        sclk_q    <= sclk_sync[SYNC_STAGES-1];
        sclk_p    <= sclk_q;
        cs_q      <= cs_sync[SYNC_STAGES-1];
        cs_p      <= cs_q;
        mosi_q    <= mosi_sync[SYNC_STAGES-1];
        mosi_p    <= mosi_q;
        sclk_rise <= sclk_q & ~sclk_p;
        cs_rise   <= cs_q & ~cs_p;
        cs_fall   <= ~cs_q & cs_p;
    end

    state_t               state, state_next;
    logic [5:0]           cnt, cnt_next;
    logic [FRAME_W-1:0]   sr, sr_next;
    logic [FRAME_W-1:0]   frame_q;
    logic                 load;
    logic                 fv_next, fe_next, ov_next, busy_next;
    logic                 fv_q, fe_q, ov_q, busy_q;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        sr_next    = sr;
        load       = 1'b0;
        fv_next    = 1'b0;
        fe_next    = 1'b0;
        ov_next    = 1'b0;
        busy_next  = busy_q;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    cnt_next   = 6'd0;
                    busy_next  = 1'b1;
                    state_next = RX;
                end
            end
            RX: begin
                if (sclk_rise) begin
                    sr_next  = {mosi_p, sr[FRAME_W-1:1]};
                    cnt_next = cnt + 6'd1;
                end
                // A 50th edge coinciding with chip-select release still completes the frame.
                if (sclk_rise && cnt == 6'd49) begin
                    load    = 1'b1;
                    fv_next = 1'b1;
                    if (cs_rise) begin
                        busy_next  = 1'b0;
                        state_next = IDLE;
                    end else begin
                        state_next = DONE;
                    end
                end else if (cs_rise) begin
                    fe_next    = (cnt != 6'd0) || sclk_rise;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            DONE: begin
                if (sclk_rise) begin
                    ov_next = 1'b1;
                end
                if (cs_rise) begin
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end else if (sclk_rise) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (cs_rise) begin
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= cs_q ? IDLE : DRAIN;
            cnt     <= 6'd0;
            sr      <= '0;
            frame_q <= '0;
            fv_q    <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            sr     <= sr_next;
            fv_q   <= fv_next;
            fe_q   <= fe_next;
            ov_q   <= ov_next;
            busy_q <= busy_next;
            if (load) begin
                frame_q <= sr_next;
            end
        end
    end

    assign bus.frame_valid = fv_q;
    assign bus.frame_err   = fe_q;
    assign bus.overrun     = ov_q;
    assign bus.busy        = busy_q;
    assign bus.cmd         = frame_q[3:0];
    assign bus.aux         = frame_q[15:4];
    assign bus.data        = frame_q[40:16];
    assign bus.dev         = frame_q[44:41];
    assign bus.wr          = frame_q[45];
    assign bus.tag         = frame_q[49:46];

`ifdef SPI_CMD_RX_MISO_EN
    logic                sclk_fall;
    logic [STATUS_W-1:0] snap;
    logic                miso_q;

    always_ff @(posedge clk) begin
        sclk_fall <= ~sclk_q & sclk_p;
    end

    // The snapshot shifts right as bits go out, so zeros follow the status word for free.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap   <= '0;
            miso_q <= 1'b0;
        end else if (state == IDLE && cs_fall) begin
            snap   <= bus.status;
            miso_q <= 1'b0;
        end else if (state == RX && state_next == RX) begin
            if (sclk_fall) begin
                miso_q <= snap[0];
                snap   <= snap >> 1;
            end
        end else begin
            miso_q <= 1'b0;
        end
    end

    assign bus.spi_miso = miso_q;
`else
    logic unused_status;
    assign unused_status = ^bus.status;
    assign bus.spi_miso  = 1'b0;
`endif
endmodule

// File: tb/tb_spi_cmd_rx.sv
module tb_spi_cmd_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #30 clk = ~clk;

    spi_cmd_rx_if #(.STATUS_W(16)) bus ();

    spi_cmd_rx #(.SYNC_STAGES(2), .STATUS_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_err = 0;
    int n_ovr = 0;
    int n_miso_hi = 0;
    logic [63:0] miso_cap;

    always @(negedge clk) begin
        if (bus.frame_valid) n_valid++;
        if (bus.frame_err)   n_err++;
        if (bus.overrun)     n_ovr++;
        if (bus.spi_miso)    n_miso_hi++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Mode 3: master drives on falling edge, both sides sample on rising edge.
    task automatic spi_bits(input logic [49:0] v, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            bus.spi_clk  = 1'b0;
            bus.spi_mosi = v[i];
            #500;
            bus.spi_clk  = 1'b1;
            miso_cap[i]  = bus.spi_miso;
            #500;
        end
    endtask

    task automatic cs_low();
        bus.spi_cs = 1'b0;
        #500;
    endtask

    task automatic cs_high();
        bus.spi_cs = 1'b1;
        #1000;
    endtask

    initial begin
        logic [49:0] f1, f2, f4;
        logic [63:0] exp_miso;
        f1 = {4'd1, 1'b1, 4'd4, 25'h1123456, 12'hCCC, 4'd2};
        f2 = {f1[49:4], 4'd5};
        f4 = {4'hA, 1'b0, 4'h3, 25'h0ABCDEF, 12'h123, 4'h9};
`ifdef SPI_CMD_RX_MISO_EN
        exp_miso = {48'd0, 16'hA5C3};
`else
        exp_miso = 64'd0;
`endif
        bus.spi_clk  = 1'b1;
        bus.spi_cs   = 1'b1;
        bus.spi_mosi = 1'b0;
        bus.status   = 16'hA5C3;
        miso_cap     = '0;
        repeat (8) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 64'(bus.frame_valid), 64'd0);
        check("rst_err",   64'(bus.frame_err),   64'd0);
        check("rst_ovr",   64'(bus.overrun),     64'd0);
        check("rst_busy",  64'(bus.busy),        64'd0);
        check("rst_miso",  64'(bus.spi_miso),    64'd0);
        check("rst_cmd",   64'(bus.cmd),         64'd0);
        check("rst_data",  64'(bus.data),        64'd0);
        check("rst_tag",   64'(bus.tag),         64'd0);

        // Frame 1, with a busy probe mid-frame
        cs_low();
        spi_bits(f1, 0, 24);
        @(negedge clk);
        check("f1_busy_mid", 64'(bus.busy), 64'd1);
        spi_bits(f1, 25, 49);
        #1000;
        @(negedge clk);
        check("f1_valid_cnt", 64'(n_valid), 64'd1);
        check("f1_err_cnt",   64'(n_err),   64'd0);
        check("f1_tag",  64'(bus.tag),  64'd1);
        check("f1_wr",   64'(bus.wr),   64'd1);
        check("f1_dev",  64'(bus.dev),  64'd4);
        check("f1_data", 64'(bus.data), 64'h1123456);
        check("f1_aux",  64'(bus.aux),  64'hCCC);
        check("f1_cmd",  64'(bus.cmd),  64'd2);
        check("f1_miso", {14'd0, miso_cap[49:0]}, exp_miso);

        // Overrun: extra clocks with chip select still low
        spi_bits(f2, 0, 4);
        #1000;
        @(negedge clk);
        check("ovr_cnt",       64'(n_ovr),    64'd1);
        check("ovr_valid_cnt", 64'(n_valid),  64'd1);
        check("ovr_cmd_hold",  64'(bus.cmd),  64'd2);
        check("ovr_data_hold", 64'(bus.data), 64'h1123456);
        cs_high();
        @(negedge clk);
        check("ovr_busy_low", 64'(bus.busy), 64'd0);

        // Frame 2 with cmd=5
        miso_cap = '0;
        cs_low();
        spi_bits(f2, 0, 49);
        cs_high();
        @(negedge clk);
        check("f2_valid_cnt", 64'(n_valid), 64'd2);
        check("f2_cmd",       64'(bus.cmd), 64'd5);
        check("f2_ovr_cnt",   64'(n_ovr),   64'd1);
        check("f2_miso", {14'd0, miso_cap[49:0]}, exp_miso);

        // Short frame: 20 bits
        cs_low();
        spi_bits(f4, 0, 19);
        cs_high();
        @(negedge clk);
        check("short_err_cnt",   64'(n_err),    64'd1);
        check("short_valid_cnt", 64'(n_valid),  64'd2);
        check("short_cmd_hold",  64'(bus.cmd),  64'd5);
        check("short_aux_hold",  64'(bus.aux),  64'hCCC);

        // Reset mid-frame, then the rest of the frame must be ignored
        cs_low();
        spi_bits(f4, 0, 29);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        spi_bits(f4, 30, 49);
        cs_high();
        @(negedge clk);
        check("mid_rst_valid_cnt", 64'(n_valid), 64'd2);
        check("mid_rst_err_cnt",   64'(n_err),   64'd1);
        check("mid_rst_ovr_cnt",   64'(n_ovr),   64'd1);

        // Clean full frame after the reset
        cs_low();
        spi_bits(f4, 0, 49);
        cs_high();
        @(negedge clk);
        check("f4_valid_cnt", 64'(n_valid),  64'd3);
        check("f4_err_cnt",   64'(n_err),    64'd1);
        check("f4_tag",  64'(bus.tag),  64'hA);
        check("f4_wr",   64'(bus.wr),   64'd0);
        check("f4_dev",  64'(bus.dev),  64'd3);
        check("f4_data", 64'(bus.data), 64'h0ABCDEF);
        check("f4_aux",  64'(bus.aux),  64'h123);
        check("f4_cmd",  64'(bus.cmd),  64'd9);
`ifndef SPI_CMD_RX_MISO_EN
        check("miso_never_high", 64'(n_miso_hi), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_cmd_rx.md
# spi_cmd_rx

Host-facing SPI slave that receives the 50-bit LSB-first command frame from the system controller and decodes it into parallel fields for the ADF4159 programming and LO control logic inside `top`. All SPI pins are oversampled on the system clock `clk`. The block presents one validated frame per chip-select assertion, and optionally shifts a status word back on `spi_miso`.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on `spi_clk`, `spi_cs` and `spi_mosi`; minimum 2.
- `STATUS_W`, default 16: width of the readback status word.
- `clk` in 1: system clock. SPI clock must be at most `clk`/4.
- `rst` in 1: synchronous, active-high reset.
- `spi_clk` in 1: SPI clock, idles high. Master drives data on falling edges; the slave samples on rising edges.
- `spi_cs` in 1: chip select, active low.
- `spi_mosi` in 1: serial data in.
- `spi_miso` out 1: serial status out.
- `status` in `STATUS_W`: status word, snapshotted at the start of each frame.
- `frame_valid` out 1: one-cycle pulse; a complete frame has been decoded.
- `frame_err` out 1: one-cycle pulse; `spi_cs` rose with a bit count from 1 to 49.
- `overrun` out 1: one-cycle pulse; a 51st rising edge occurred in the same `spi_cs` assertion.
- `busy` out 1: high while `spi_cs` is low (synchronized) and the receiver is armed.
- `cmd` out 4: frame bits [3:0].
- `aux` out 12: frame bits [15:4].
- `data` out 25: frame bits [40:16].
- `dev` out 4: frame bits [44:41].
- `wr` out 1: frame bit [45].
- `tag` out 4: frame bits [49:46].

## Operation
- States are IDLE, RX, DONE and DRAIN.
- **IDLE**
  - Waits for a synchronized falling edge of `spi_cs`.
  - On that edge: clear the bit counter, snapshot `status`, drive `spi_miso`=0, go to RX.
- **RX**
  - On each synchronized `spi_clk` rising edge: shift the delayed `spi_mosi` into bit position `count` (the first bit received is bit 0), then increment `count`.
  - When `count` reaches 50: load all field outputs from the shift register, pulse `frame_valid`, go to DONE.
  - `spi_cs` rise with `count` from 1 to 49: pulse `frame_err`, fields unchanged, go to IDLE.
  - `spi_cs` rise with `count`=0: go to IDLE silently.
- **DONE**
  - Further `spi_clk` rising edges while `spi_cs` is low: pulse `overrun` once on the first such edge, go to DRAIN.
  - `spi_cs` rise: go to IDLE.
- **DRAIN**
  - Ignores all `spi_clk` edges until `spi_cs` rises, then goes to IDLE.
- **Field outputs**
  - Registered and held until the next `frame_valid`.
  - A frame already accepted is never retracted by a later `overrun` or `frame_err`.
- **Simultaneous events**
  - 50th rising edge and `spi_cs` rise detected in the same cycle: the frame is accepted (`frame_valid`, no `frame_err`).
- **Reset**
  - Reset mid-frame discards the partial frame.
  - After reset the block goes to DRAIN if synchronized `spi_cs` is low, otherwise to IDLE. A frame already in progress is never half-decoded.

## Timing
- Synchronized edge detection is registered. A pin transition is visible as an edge-detect pulse `SYNC_STAGES`+1 `clk` cycles after the first `clk` edge that samples it.
- `frame_valid` and the field update occur in the same cycle, 1 cycle after the 50th rising-edge detect pulse. Total latency is `SYNC_STAGES`+2 cycles.
- `frame_err` occurs 1 cycle after the `spi_cs` rising-edge detect.
- `busy` rises 1 cycle after the `spi_cs` fall detect and falls 1 cycle after the `spi_cs` rise detect.
- Reset values: `spi_miso`=0; `frame_valid`, `frame_err`, `overrun` and `busy`=0; all field outputs 0; state IDLE or DRAIN as above.

## Configuration
- `SPI_CMD_RX_MISO_EN` defined:
  - On each synchronized `spi_clk` falling edge in RX, `spi_miso` is registered to the next status snapshot bit, starting at bit 0 (LSB-first).
  - After `STATUS_W` bits, `spi_miso` drives 0.
  - Outside RX, `spi_miso`=0.
- Not defined: `spi_miso` is tied to 0, `status` is unused, and no snapshot register exists.

## Test plan
- Mode-3 master with a 1000 ns SPI period and a 60 ns `clk` sends 50 bits LSB-first of the value with bits[49:46]=1, [45]=1, [44:41]=4, [40:16]=0x1123456, [15:4]=0xCCC, [3:0]=2. Required: one `frame_valid`, `tag`=1, `wr`=1, `dev`=4, `data`=0x1123456, `aux`=0xCCC, `cmd`=2.
- After the same frame, `spi_cs` stays low and `spi_clk` keeps toggling. Required: exactly one `overrun`, fields unchanged, no second `frame_valid`. Then `spi_cs` rises and a second frame with `cmd`=5 is sent: required `frame_valid` with `cmd`=5.
- 20 bits sent, then `spi_cs` rises. Required: `frame_err` pulse, no `frame_valid`, fields hold the previous values.
- `rst` asserted after bit 30 with `spi_cs` held low, then 20 more bits, `spi_cs` rise, then a full frame. Required: no pulse of any kind until the full frame, then `frame_valid` with the correct fields.
- With `SPI_CMD_RX_MISO_EN` and `status`=0xA5C3: capturing `spi_miso` on master rising edges yields 0xA5C3 LSB-first, then 34 zeros. Without the macro, `spi_miso` stays 0 throughout.
